// File: rtl/ram_arb.sv
// ram_arb: single-port word RAM shared by NPORTS requestors.
// One requestor holds the grant at a time. After LAT wait cycles the grantee
// reaches ACCESS: reads return data combinationally, and writes commit on
// every edge for as long as ACCESS holds.
// Build option RAM_ARB_RR_EN selects round-robin arbitration. When it is
// undefined, the lowest valid index wins.
module ram_arb #(
    parameter int              NPORTS = 2,
    parameter int              DW     = 32,
    parameter int              AW     = 16,
    parameter int              LAT    = 6,
    parameter logic [DW-1:0]   BAD    = 32'hBAD1BAD1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NPORTS-1:0]      ren,
    input  logic [NPORTS-1:0]      wen,
    input  logic [NPORTS*AW-1:0]   addr,
    input  logic [NPORTS*DW-1:0]   store,
    output logic [NPORTS*DW-1:0]   load,
    output logic [NPORTS*2-1:0]    state
);

    localparam int          IW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int          MW    = 2 ** (AW - 2);
    localparam logic [3:0]  LAT_C = 4'(LAT);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERROR  = 2'd3
    } port_st_e;

    logic [DW-1:0]     mem [0:MW-1];

    logic [NPORTS-1:0] valid;
    logic              gnt_vld_q, gnt_vld_d;
    logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
    logic [AW-1:0]     lat_addr_q, lat_addr_d;
    logic              lat_ren_q, lat_ren_d;
    logic              lat_wen_q, lat_wen_d;
    logic [3:0]        cnt_q, cnt_d;
`ifdef RAM_ARB_RR_EN
    logic [IW-1:0]     ptr_q, ptr_d;
`endif

    logic              hold;
    logic              access;
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;

    assign valid = ren ^ wen;

    // Grantee keeps its grant only while it presents the latched addr/mode unchanged.
    always_comb begin
        hold = gnt_vld_q && valid[gnt_idx_q]
               && (addr[gnt_idx_q*AW +: AW] == lat_addr_q)
               && (ren[gnt_idx_q] == lat_ren_q)
               && (wen[gnt_idx_q] == lat_wen_q);
        access = hold && (cnt_q >= LAT_C) && !RST;
    end

    // Choose the next grantee among ports valid in this cycle.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
`ifdef RAM_ARB_RR_EN
        for (int k = 0; k < NPORTS; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NPORTS) j = j - NPORTS;
            if (!pick_vld && valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
`else
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (valid[k]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(k);
            end
        end
`endif
    end

    // Next-state: advance the wait counter while held, otherwise re-arbitrate.
    always_comb begin
        gnt_vld_d  = gnt_vld_q;
        gnt_idx_d  = gnt_idx_q;
        lat_addr_d = lat_addr_q;
        lat_ren_d  = lat_ren_q;
        lat_wen_d  = lat_wen_q;
        cnt_d      = cnt_q;
`ifdef RAM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        if (hold) begin
            if (cnt_q < LAT_C) cnt_d = cnt_q + 4'd1;
        end else begin
            gnt_vld_d = pick_vld;
            cnt_d     = '0;
            if (pick_vld) begin
                gnt_idx_d  = pick_idx;
                lat_addr_d = addr[pick_idx*AW +: AW];
                lat_ren_d  = ren[pick_idx];
                lat_wen_d  = wen[pick_idx];
`ifdef RAM_ARB_RR_EN
                ptr_d      = (pick_idx == IW'(NPORTS - 1)) ? '0 : pick_idx + IW'(1);
`endif
            end
        end
    end

    // Control state: grant flag, wait counter and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_vld_q <= 1'b0;
            cnt_q     <= '0;
`ifdef RAM_ARB_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            gnt_vld_q <= gnt_vld_d;
            cnt_q     <= cnt_d;
`ifdef RAM_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // Latched grantee identity and request; only meaningful while gnt_vld_q is set.
    always_ff @(posedge CLK) begin
        gnt_idx_q  <= gnt_idx_d;
        lat_addr_q <= lat_addr_d;
        lat_ren_q  <= lat_ren_d;
        lat_wen_q  <= lat_wen_d;
    end

    // Memory write on every edge where a write grantee is in ACCESS; reset never writes.
    always_ff @(posedge CLK) begin
        if (access && lat_wen_q) begin
            mem[lat_addr_q[AW-1:2]] <= store[gnt_idx_q*DW +: DW];
        end
    end

    // Per-port status and read data.
    always_comb begin
        port_st_e st;
        for (int i = 0; i < NPORTS; i++) begin
            st = ST_FREE;
            load[i*DW +: DW] = BAD;
            if (ren[i] && wen[i]) begin
                st = ST_ERROR;
            end else if (ren[i] || wen[i]) begin
                if (access && (gnt_idx_q == IW'(i))) begin
                    st = ST_ACCESS;
                    if (ren[i]) load[i*DW +: DW] = mem[lat_addr_q[AW-1:2]];
                end else begin
                    st = ST_BUSY;
                end
            end
            state[i*2 +: 2] = st;
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: per-cycle vector table for ram_arb (NPORTS=2, LAT=6), plus a
// hand-written arbitration-order sequence.
module tb_ram_arb;

    localparam logic [31:0] BADV = 32'hBAD1BAD1;
    localparam logic [1:0]  FR = 2'd0, BS = 2'd1, AC = 2'd2, ER = 2'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  ren = 2'b00;
    logic [1:0]  wen = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [63:0] store = 64'h0;
    logic [63:0] load;
    logic [3:0]  state;

    ram_arb dut (
        .CLK   (CLK),
        .RST   (RST),
        .ren   (ren),
        .wen   (wen),
        .addr  (addr),
        .store (store),
        .load  (load),
        .state (state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [1:0]  ren;
        logic [1:0]  wen;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [31:0] d0;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [31:0] l0;
        logic [31:0] l1;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int n, input logic rst, input logic [1:0] r, input logic [1:0] w,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [31:0] d0,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic [31:0] l0, input logic [31:0] l1);
        vec_t v;
        v.rst = rst; v.ren = r; v.wen = w; v.a0 = a0; v.a1 = a1; v.d0 = d0;
        v.s0 = s0; v.s1 = s1; v.l0 = l0; v.l1 = l1;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    initial begin
        int who;
        int exp_who;

        // reset, then a reset cycle with a request present
        add(1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(1, 1'b1, 2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0,        BS, FR, BADV, BADV);
        // port0 writes 0x12345678 to 0x0010
        add(7, 1'b0, 2'b00, 2'b01, 16'h0010, 16'h0000, 32'h12345678, BS, FR, BADV, BADV);
        add(1, 1'b0, 2'b00, 2'b01, 16'h0010, 16'h0000, 32'h12345678, AC, FR, BADV, BADV);
        // reset keeps memory; read back mem[4]
        add(1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(7, 1'b0, 2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0,        BS, FR, BADV, BADV);
        add(2, 1'b0, 2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0,        AC, FR, 32'h12345678, BADV);
        // mode change to write at 0x0020, then read it back
        add(7, 1'b0, 2'b00, 2'b01, 16'h0020, 16'h0000, 32'hDEADBEEF, BS, FR, BADV, BADV);
        add(1, 1'b0, 2'b00, 2'b01, 16'h0020, 16'h0000, 32'hDEADBEEF, AC, FR, BADV, BADV);
        add(7, 1'b0, 2'b01, 2'b00, 16'h0020, 16'h0000, 32'h0,        BS, FR, BADV, BADV);
        add(1, 1'b0, 2'b01, 2'b00, 16'h0020, 16'h0000, 32'h0,        AC, FR, 32'hDEADBEEF, BADV);
        // byte offset bits ignored; addr change forces re-grant
        add(7, 1'b0, 2'b01, 2'b00, 16'h0023, 16'h0000, 32'h0,        BS, FR, BADV, BADV);
        add(1, 1'b0, 2'b01, 2'b00, 16'h0023, 16'h0000, 32'h0,        AC, FR, 32'hDEADBEEF, BADV);
        // contention: port0 wins, port1 follows after port0 drops
        add(1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(7, 1'b0, 2'b11, 2'b00, 16'h0010, 16'h0020, 32'h0,        BS, BS, BADV, BADV);
        add(1, 1'b0, 2'b11, 2'b00, 16'h0010, 16'h0020, 32'h0,        AC, BS, 32'h12345678, BADV);
        add(7, 1'b0, 2'b10, 2'b00, 16'h0010, 16'h0020, 32'h0,        FR, BS, BADV, BADV);
        add(1, 1'b0, 2'b10, 2'b00, 16'h0010, 16'h0020, 32'h0,        FR, AC, BADV, 32'hDEADBEEF);
        // port0 ERROR never granted; port1 proceeds
        add(1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(7, 1'b0, 2'b11, 2'b01, 16'h0010, 16'h0010, 32'h0,        ER, BS, BADV, BADV);
        add(1, 1'b0, 2'b11, 2'b01, 16'h0010, 16'h0010, 32'h0,        ER, AC, BADV, 32'h12345678);
        // grantee turns ERROR: grant released, returning needs full latency
        add(1, 1'b0, 2'b11, 2'b11, 16'h0010, 16'h0010, 32'h0,        ER, ER, BADV, BADV);
        add(7, 1'b0, 2'b10, 2'b00, 16'h0000, 16'h0010, 32'h0,        FR, BS, BADV, BADV);
        add(1, 1'b0, 2'b10, 2'b00, 16'h0000, 16'h0010, 32'h0,        FR, AC, BADV, 32'h12345678);
        // reset at count=3 of a write aborts it; memory keeps old value
        add(1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(4, 1'b0, 2'b00, 2'b01, 16'h0010, 16'h0000, 32'hCAFEF00D, BS, FR, BADV, BADV);
        add(1, 1'b1, 2'b00, 2'b01, 16'h0010, 16'h0000, 32'hCAFEF00D, BS, FR, BADV, BADV);
        add(1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(2, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0,        FR, FR, BADV, BADV);
        add(7, 1'b0, 2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0,        BS, FR, BADV, BADV);
        add(1, 1'b0, 2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0,        AC, FR, 32'h12345678, BADV);

        @(posedge CLK);
        #1;
        foreach (vq[i]) begin
            RST   = vq[i].rst;
            ren   = vq[i].ren;
            wen   = vq[i].wen;
            addr  = {vq[i].a1, vq[i].a0};
            store = {32'h0, vq[i].d0};
            @(negedge CLK);
            checks++;
            if (state !== {vq[i].s1, vq[i].s0}) begin
                errors++;
                $display("FAIL vec_state row %0d: got %b want %b", i, state, {vq[i].s1, vq[i].s0});
            end
            checks++;
            if (load !== {vq[i].l1, vq[i].l0}) begin
                errors++;
                $display("FAIL vec_load row %0d: got %h want %h", i, load, {vq[i].l1, vq[i].l0});
            end
            @(posedge CLK);
            #1;
        end

        // arbitration order with both ports reading and re-addressing after each ACCESS
        RST = 1'b1; ren = 2'b00; wen = 2'b00;
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        ren  = 2'b11;
        addr = {16'h0020, 16'h0010};
        for (int g = 0; g < 4; g++) begin
            who = -1;
            for (int c = 0; c < 20 && who < 0; c++) begin
                @(negedge CLK);
                if (state[1:0] == AC) who = 0;
                else if (state[3:2] == AC) who = 1;
                @(posedge CLK);
                #1;
            end
`ifdef RAM_ARB_RR_EN
            exp_who = g % 2;
`else
            exp_who = 0;
`endif
            checks++;
            if (who != exp_who) begin
                errors++;
                $display("FAIL arb_order grant %0d: got port %0d want port %0d", g, who, exp_who);
            end
            if (who == 0) addr[15:0]  = addr[15:0]  ^ 16'h0004;
            if (who == 1) addr[31:16] = addr[31:16] ^ 16'h0004;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter NPORTS, default 2: number of requestor ports, legal range 1..8.
REQ-002 Parameter DW, default 32: data word width in bits.
REQ-003 Parameter AW, default 16: byte-address width; word index is addr[AW-1:2].
REQ-004 Parameter LAT, default 6: wait cycles from grant to ACCESS, legal range 0..15.
REQ-005 Parameter BAD, default 32'hBAD1BAD1: value driven on load when not in ACCESS.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-008 ren  in  NPORTS  per-port read request.
REQ-009 wen  in  NPORTS  per-port write request.
REQ-010 addr  in  NPORTS*AW  per-port byte address, port i at [i*AW +: AW].
REQ-011 store  in  NPORTS*DW  per-port write data.
REQ-012 load  out  NPORTS*DW  per-port read data.
REQ-013 state  out  NPORTS*2  per-port status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-014 Memory shall hold 2**(AW-2) words of DW bits, indexed by addr[AW-1:2]; addr[1:0] ignored.
REQ-015 Port i is valid when exactly one of ren[i], wen[i] is set; both set gives state ERROR, and the port is never granted.
REQ-016 A port with ren=wen=0 shall report FREE and load=BAD.
REQ-017 At most one port is granted at a time; the grant register and latched {addr, ren, wen} of the grantee update on a clock edge.
REQ-018 When no grant is held, at each edge the arbiter grants one valid port (REQ-033/034), latches its addr/mode, and clears the counter to 0.
REQ-019 While the grantee keeps the same addr and mode, the counter shall increment by 1 per cycle, saturating at LAT.
REQ-020 Grantee state shall be ACCESS when count>=LAT and its current addr/mode equal the latched values; otherwise BUSY.
REQ-021 Valid non-granted ports shall report BUSY with load=BAD.
REQ-022 In ACCESS with ren, load for that port shall be mem[word index] combinationally; all other ports get BAD.
REQ-023 In ACCESS with wen, store shall be written to mem at each edge while ACCESS holds (repeat writes idempotent).
REQ-024 If the grantee drops its request, changes addr, or changes mode, the grant shall release at that edge, and arbitration occurs at that same edge among ports valid in that cycle.
REQ-025 A grantee changing addr while still valid may be re-granted at the same edge, restarting count at 0.
REQ-026 With LAT=0, ACCESS shall appear the cycle after the granting edge.
REQ-027 Minimum access latency: LAT+1 cycles from first request cycle to ACCESS when uncontended.
REQ-028 Grantee turning ERROR (both enables set) shall release the grant at the next edge.

Reset
REQ-029 While RST is sampled high: grant cleared, count=0, round-robin pointer=0.
REQ-030 Outputs during and after reset, until a grant: all ports state per REQ-015/016/021 (never ACCESS); load=BAD.
REQ-031 Memory contents shall not be altered by reset; no write occurs in a reset cycle.
REQ-032 Reset asserted mid-access aborts the access; any in-progress write has completed only for edges already past.

Configuration
REQ-033 With RAM_ARB_RR_EN defined: round-robin; pointer moves to (granted index+1) mod NPORTS on each grant; search starts at pointer.
REQ-034 Without RAM_ARB_RR_EN: fixed priority, lowest valid index wins; no pointer register exists.

Verification
REQ-035 Reset, port0 ren, addr=0x0010, LAT=6 -> state0 BUSY 6 cycles after grant edge, ACCESS cycle 7, load=mem[4]; port1 FREE, load1=0xBAD1BAD1.
REQ-036 Port0 wen addr=0x0020 store=0xDEADBEEF to ACCESS, then ren same addr -> new grant, ACCESS after LAT+1, load0=0xDEADBEEF.
REQ-037 Ports 0 and 1 both ren from same cycle -> port0 granted, port1 BUSY; after port0 drops, port1 ACCESS after LAT+1 more cycles.
REQ-038 RAM_ARB_RR_EN defined, ports 0,1 ren continuously with addr toggled after each ACCESS -> grants alternate 0,1,0,1; undefined -> port0 always wins.
REQ-039 Port0 ren and wen both 1 -> state0=ERROR, never granted; port1 ren meanwhile reaches ACCESS normally.
REQ-040 RST high at count=3 of a write -> no ACCESS, mem unchanged; after release, state FREE until new request.
